// File: rtl/hazard_scheduler_pkg.sv
// Shared types and constants for the ID-stage issue controller and its scoreboard.
package hazard_scheduler_pkg;
  localparam int REG_W = 8;
  localparam int NUM_REGS = 1 << REG_W;
  localparam logic [REG_W-1:0] ZERO_REG = 8'hff;

  typedef enum logic [1:0] {UNIT_ALU, UNIT_FPU, UNIT_BU, UNIT_DEV} unit_t;
  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} sched_state_t;
endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write bits with three source read ports and a dest read port.
module hazard_scoreboard
  import hazard_scheduler_pkg::*;
#(
  parameter int REG_W = hazard_scheduler_pkg::REG_W,
  parameter int NUM_REGS = 1 << REG_W,
  parameter logic [REG_W-1:0] ZERO_REG = hazard_scheduler_pkg::ZERO_REG
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2:0][REG_W-1:0]  src,
  input  logic [REG_W-1:0]       dest,
  input  logic                   set_en,
  input  logic                   clr_en,
  input  logic [REG_W-1:0]       clr_addr,
  output logic [2:0]             src_pend,
  output logic                   dest_pend,
  output logic                   any_pending
);
  logic [NUM_REGS-1:0] pending;

  // Set is applied after clear so a same-register set/clear leaves the bit set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      if (clr_en) pending[clr_addr] <= 1'b0;
      if (set_en && dest != ZERO_REG) pending[dest] <= 1'b1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_rd
    assign src_pend[i] = pending[src[i]] & (src[i] != ZERO_REG);
  end

  assign dest_pend   = pending[dest] & (dest != ZERO_REG);
  assign any_pending = |pending;
endmodule

// File: rtl/hazard_scheduler.sv
// In-order issue controller: RAW/WAW/structural hazard detection, flush, halt drain, stall counter.
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int REG_W = hazard_scheduler_pkg::REG_W,
  parameter int NUM_REGS = 1 << REG_W,
  parameter logic [REG_W-1:0] ZERO_REG = hazard_scheduler_pkg::ZERO_REG,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [1:0]       id_unit,
  input  logic             id_writes,
  input  logic [REG_W-1:0] id_dest,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic [REG_W-1:0] id_src3,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             id_use3,
  input  logic             id_halt,
  input  logic             wb_enable,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             dev_done,
  input  logic             pred_failed,
  input  logic             jr_taken,
  output logic             stall,
  output logic             flush,
  output logic             issue,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);
  sched_state_t          state;
  logic                  dev_busy;
  logic [2:0][REG_W-1:0] src;
  logic [2:0]            use_src;
  logic [2:0]            src_pend;
  logic [2:0]            fwd;
  logic                  dest_pend;
  logic                  any_pending;
  logic                  in_run;
  logic                  is_dev;
  logic                  raw;
  logic                  waw;
  logic                  strc;
  logic                  hazard;

  assign src     = {id_src3, id_src2, id_src1};
  assign use_src = {id_use3, id_use2, id_use1};

  hazard_scoreboard #(
    .REG_W    (REG_W),
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clock       (clock),
    .reset       (reset),
    .src         (src),
    .dest        (id_dest),
    .set_en      (issue & id_writes),
    .clr_en      (wb_enable),
    .clr_addr    (wb_dest),
    .src_pend    (src_pend),
    .dest_pend   (dest_pend),
    .any_pending (any_pending)
  );

  // A source being written back this cycle is forwarded by the register file.
  for (genvar i = 0; i < 3; i++) begin : g_fwd
    assign fwd[i] = wb_enable & (wb_dest == src[i]);
  end

  assign in_run = (state == ST_RUN);
  assign is_dev = (unit_t'(id_unit) == UNIT_DEV);
  assign raw    = |(use_src & src_pend & ~fwd);
  assign waw    = id_writes & dest_pend & ~(wb_enable & (wb_dest == id_dest));
  assign strc   = is_dev & dev_busy & ~dev_done;
  assign hazard = in_run & id_valid & (raw | waw | strc);

  assign flush  = (pred_failed | jr_taken) & ~reset;
  assign stall  = reset | (hazard & ~flush) | ~in_run;
  assign issue  = ~reset & in_run & id_valid & ~hazard & ~flush & ~id_halt;
  assign halted = ~reset & (state == ST_HALTED);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_RUN;
      dev_busy     <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (issue && is_dev)  dev_busy <= 1'b1;
      else if (dev_done)    dev_busy <= 1'b0;

      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);

      case (state)
        ST_RUN:   if (id_valid && id_halt && !flush) state <= ST_DRAIN;
        ST_DRAIN: if (!any_pending && !dev_busy)     state <= ST_HALTED;
        default:  state <= ST_HALTED;
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_scheduler.sv
// Random + directed bench; a per-register/flag model predicts every output each cycle.
module tb_hazard_scheduler;
  localparam logic [7:0] ZR = 8'hff;

  logic       clock = 1'b0;
  logic       reset;
  logic       id_valid, id_writes, id_halt;
  logic [1:0] id_unit;
  logic [7:0] id_dest, id_src1, id_src2, id_src3, wb_dest;
  logic       id_use1, id_use2, id_use3;
  logic       wb_enable, dev_done, pred_failed, jr_taken;
  logic       stall, flush, issue, halted;
  logic [31:0] stall_cycles;
  logic       stall4, flush4, issue4, halted4;
  logic [3:0] stall_cycles4;

  always #5 clock = ~clock;

  hazard_scheduler dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_unit(id_unit),
    .id_writes(id_writes), .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2),
    .id_src3(id_src3), .id_use1(id_use1), .id_use2(id_use2), .id_use3(id_use3),
    .id_halt(id_halt), .wb_enable(wb_enable), .wb_dest(wb_dest), .dev_done(dev_done),
    .pred_failed(pred_failed), .jr_taken(jr_taken), .stall(stall), .flush(flush),
    .issue(issue), .halted(halted), .stall_cycles(stall_cycles)
  );

  hazard_scheduler #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_unit(id_unit),
    .id_writes(id_writes), .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2),
    .id_src3(id_src3), .id_use1(id_use1), .id_use2(id_use2), .id_use3(id_use3),
    .id_halt(id_halt), .wb_enable(wb_enable), .wb_dest(wb_dest), .dev_done(dev_done),
    .pred_failed(pred_failed), .jr_taken(jr_taken), .stall(stall4), .flush(flush4),
    .issue(issue4), .halted(halted4), .stall_cycles(stall_cycles4)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0=running, 1=draining, 2=halted
  bit [255:0]  m_pend;
  bit          m_busy;
  int          m_st;
  int unsigned m_cnt;
  int unsigned m_cnt4;

  task automatic clr_in();
    reset = 0; id_valid = 0; id_unit = 0; id_writes = 0; id_halt = 0;
    id_dest = 0; id_src1 = 0; id_src2 = 0; id_src3 = 0;
    id_use1 = 0; id_use2 = 0; id_use3 = 0;
    wb_enable = 0; wb_dest = 0; dev_done = 0; pred_failed = 0; jr_taken = 0;
  endtask

  // Inputs are already applied; check this cycle, then advance the model to the next edge.
  task automatic tick();
    bit [7:0] s [3];
    bit       u [3];
    bit e_flush, e_stall, e_issue, e_halted, blocked, any;
    s[0] = id_src1; s[1] = id_src2; s[2] = id_src3;
    u[0] = id_use1; u[1] = id_use2; u[2] = id_use3;
    #1;
    if (reset) begin
      m_pend = '0; m_busy = 0; m_st = 0; m_cnt = 0; m_cnt4 = 0;
    end
    blocked = 0;
    for (int k = 0; k < 3; k++)
      if (u[k] && s[k] != ZR && m_pend[s[k]] && !(wb_enable && wb_dest == s[k])) blocked = 1;
    if (id_writes && id_dest != ZR && m_pend[id_dest] && !(wb_enable && wb_dest == id_dest))
      blocked = 1;
    if (id_unit == 2'd3 && m_busy && !dev_done) blocked = 1;
    blocked  = blocked && m_st == 0 && id_valid;
    e_flush  = (pred_failed || jr_taken) && !reset;
    e_stall  = reset || (blocked && !e_flush) || m_st != 0;
    e_issue  = !reset && m_st == 0 && id_valid && !blocked && !e_flush && !id_halt;
    e_halted = !reset && m_st == 2;
    chk("stall", 32'(stall), 32'(e_stall));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("issue", 32'(issue), 32'(e_issue));
    chk("halted", 32'(halted), 32'(e_halted));
    chk("stall_cycles", stall_cycles, m_cnt);
    chk("stall_cycles4", 32'(stall_cycles4), m_cnt4);
    if (!reset) begin
      any = (m_pend != '0);
      if (m_st == 0 && id_valid && id_halt && !e_flush) m_st = 1;
      else if (m_st == 1 && !any && !m_busy) m_st = 2;
      if (wb_enable) m_pend[wb_dest] = 0;
      if (e_issue && id_writes && id_dest != ZR) m_pend[id_dest] = 1;
      if (e_issue && id_unit == 2'd3) m_busy = 1;
      else if (dev_done) m_busy = 0;
      if (e_stall && m_cnt != 32'hffff_ffff) m_cnt++;
      if (e_stall && m_cnt4 != 15) m_cnt4++;
    end
    @(negedge clock);
  endtask

  function automatic logic [7:0] pick_reg();
    int r = $urandom_range(0, 9);
    return (r >= 8) ? ZR : 8'(r);
  endfunction

  initial begin
    clr_in();
    reset = 1;
    @(negedge clock);
    tick(); tick();

    // RAW on r5, released by same-cycle writeback
    clr_in(); id_valid = 1; id_writes = 1; id_dest = 5; tick();
    clr_in(); id_valid = 1; id_src1 = 5; id_use1 = 1; tick(); tick(); tick();
    wb_enable = 1; wb_dest = 5; tick();

    // zero register is never pending
    clr_in(); id_valid = 1; id_writes = 1; id_dest = ZR; tick();
    clr_in(); id_valid = 1; id_src1 = ZR; id_use1 = 1; id_writes = 1; id_dest = ZR; tick();

    // device busy: second DEV stalls, then issues on dev_done
    clr_in(); id_valid = 1; id_unit = 3; tick();
    tick(); tick(); tick();
    dev_done = 1; tick();
    clr_in(); tick();

    // flush of a stalled RAW instruction
    clr_in(); id_valid = 1; id_writes = 1; id_dest = 7; tick();
    clr_in(); id_valid = 1; id_src2 = 7; id_use2 = 1; id_writes = 1; id_dest = 9;
    pred_failed = 1; tick();
    pred_failed = 0; tick();
    wb_enable = 1; wb_dest = 7; tick();

    // halt drain with r3 pending and device busy, then counter saturation
    clr_in(); id_valid = 1; id_writes = 1; id_dest = 3; tick();
    clr_in(); id_valid = 1; id_unit = 3; tick();
    clr_in(); id_valid = 1; id_halt = 1; tick();
    clr_in(); tick(); tick();
    wb_enable = 1; wb_dest = 3; tick();
    clr_in(); dev_done = 1; tick();
    clr_in(); jr_taken = 1; tick();
    clr_in();
    for (int i = 0; i < 20; i++) tick();
    reset = 1; tick();
    reset = 0; tick();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      clr_in();
      if ($urandom_range(0, 149) == 0 || (m_st == 2 && $urandom_range(0, 7) == 0)) reset = 1;
      id_valid    = ($urandom_range(0, 3) != 0);
      id_unit     = 2'($urandom_range(0, 3));
      id_writes   = $urandom_range(0, 1);
      id_dest     = pick_reg();
      id_src1     = pick_reg();
      id_src2     = pick_reg();
      id_src3     = pick_reg();
      id_use1     = $urandom_range(0, 1);
      id_use2     = $urandom_range(0, 1);
      id_use3     = $urandom_range(0, 1);
      id_halt     = ($urandom_range(0, 59) == 0);
      wb_enable   = ($urandom_range(0, 2) == 0);
      wb_dest     = pick_reg();
      dev_done    = ($urandom_range(0, 3) == 0);
      pred_failed = ($urandom_range(0, 11) == 0);
      jr_taken    = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
Central issue controller for the in-order pipeline. Every cycle it decides whether the instruction in the ID stage may issue to the ALU, FPU, branch unit or device, or must stall or be flushed. It keeps a per-register pending-write scoreboard and a single-outstanding device-busy flag. It also sequences the halt drain.
Its stall output drives the `stall` input of the IF and ID stages; its flush output squashes the ID instruction.

Parameters:
REG_W, 8, register index width
NUM_REGS, 256, scoreboard entries (2**REG_W)
ZERO_REG, 8'hff, hardwired-zero register; never pending, never a hazard
CNT_W, 32, stall-cycle counter width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
id_valid  in  1  ID stage holds a real (non-bubble) instruction
id_unit  in  2  target unit: 0 ALU, 1 FPU, 2 BU, 3 DEV
id_writes  in  1  instruction writes id_dest
id_dest  in  REG_W  destination register
id_src1 / id_src2 / id_src3  in  REG_W each  source registers (src3 = dest field read as a source)
id_use1 / id_use2 / id_use3  in  1 each  corresponding source is actually read
id_halt  in  1  ID instruction is halt
wb_enable  in  1  register-file write this cycle
wb_dest  in  REG_W  register being written
dev_done  in  1  device/cache access completed (one-cycle pulse)
pred_failed  in  1  branch mispredict from EX
jr_taken  in  1  indirect jump resolved
stall  out  1  freeze IF/ID
flush  out  1  squash ID instruction
issue  out  1  ID instruction dispatched this cycle
halted  out  1  core fully drained after halt
stall_cycles  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
- State machine RUN / DRAIN / HALTED.
  - Reset: state=RUN, all scoreboard bits 0, dev_busy=0, stall_cycles=0.
  - While reset is high: stall=1, issue=0, flush=0, halted=0.
- flush = (pred_failed | jr_taken) & ~reset, combinational.
  - Flush overrides stall: issue=0, no scoreboard set, no state change from the flushed instruction.
- Hazards (RUN, id_valid=1):
  - RAW: any used srcN with srcN != ZERO_REG and pending[srcN]=1.
  - A source equal to wb_dest while wb_enable=1 is NOT a hazard, because the register file falls through the write value.
  - WAW: id_writes=1, id_dest != ZERO_REG, pending[id_dest]=1, and not cleared this cycle.
  - Structural: id_unit=DEV and dev_busy=1 and dev_done=0.
- Issue and stall:
  - issue = RUN & id_valid & ~hazard & ~flush & ~id_halt.
  - stall = (hazard & id_valid & ~flush) | state != RUN, all combinational.
- Scoreboard update at the clock edge:
  - Clear: if wb_enable=1, pending[wb_dest] <= 0.
  - Set: if issue=1 and id_writes=1 and id_dest != ZERO_REG, pending[id_dest] <= 1.
  - Same register set and cleared in one cycle: set wins.
  - pending[ZERO_REG] is constant 0.
- dev_busy update at the clock edge:
  - Set on issue with id_unit=DEV.
  - Cleared on dev_done.
  - Simultaneous set and done: stays 1.
  - dev_done while dev_busy=0 is ignored.
- Halt:
  - In RUN, id_valid & id_halt & ~flush: move to DRAIN. The halt itself never issues.
  - In DRAIN, when every pending bit is 0 and dev_busy=0, move to HALTED on the next edge.
  - In HALTED: halted=1 and stall=1, held until reset.
  - flush in DRAIN or HALTED has no effect on state.
- Latency:
  - stall, issue and flush respond in the same cycle as their inputs.
  - Scoreboard and dev_busy changes are visible to hazard checks from the next cycle.
- stall_cycles increments every cycle in which stall=1 and reset=0. It saturates at all-ones with no wrap.
- Asserting reset mid-operation (any state, pending bits set, dev_busy=1) clears everything asynchronously. Only counting resumes after reset release; issue and stall follow their normal rules.

Decomposition:
- Shared package holds:
  - unit_t enum (ALU, FPU, BU, DEV)
  - sched_state_t enum (RUN, DRAIN, HALTED)
  - ZERO_REG and REG_W constants
- One sub-module, hazard_scoreboard: 256-bit pending vector; three read ports plus a dest read port; set/clear write logic; any_pending output.
- FSM, device flag and counter stay in hazard_scheduler.

Test Plan:
- ALU issues dest=5 at cycle 0. Next cycle an instruction with src1=5 waits: stall=1 until wb_enable=1 with wb_dest=5. In that wb cycle stall=0 and issue=1.
- Source reads ZERO_REG with id_use1=1 while a prior instruction wrote dest=8'hff: never stalls. pending stays 0.
- DEV issue sets dev_busy. A second DEV instruction stalls for 3 cycles. dev_done pulses: issue=1 in that same cycle and dev_busy remains 1.
- Stalled RAW instruction with pred_failed=1: flush=1, stall=0, issue=0, and the scoreboard is unchanged on the next cycle.
- Halt with pending[3]=1 and dev_busy=1: state DRAIN, stall=1. After wb_dest=3 and dev_done, halted=1 one cycle later. Assert reset: halted=0, stall_cycles=0.
- Preload stall_cycles near all-ones (CNT_W=4 build) and hold stall: counter sticks at 4'hf.
